// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with private HI/LO registers and MTHI/MTLO writes.
// The result is computed when the operation is accepted and committed after a fixed latency.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [4:0] MULT_LOAD = MULT_CYCLES[4:0];
  localparam logic [4:0] DIV_LOAD  = DIV_CYCLES[4:0];

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic [4:0]  cnt, cnt_next;
  logic [2:0]  op_q, op_next;
  logic [63:0] pending, pending_next;
  logic        zero_q, zero_next;
  logic [31:0] hi_next, lo_next;
  logic        done_next;

  logic [63:0] mul_s, mul_u, result;
  logic [31:0] a_mag, b_mag, b_sdiv, q_mag, r_mag, q_s, r_s;
  logic [31:0] b_udiv, q_u, r_u;
  logic        commit_ok;

  // Signed divide works on magnitudes; a zero divisor is replaced by 1 so the
  // divider never sees zero (its result is discarded at commit anyway).
  always_comb begin
    mul_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    mul_u  = {32'd0, a} * {32'd0, b};
    a_mag  = a[31] ? (~a + 32'd1) : a;
    b_mag  = b[31] ? (~b + 32'd1) : b;
    b_sdiv = (b == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_sdiv;
    r_mag  = a_mag % b_sdiv;
    q_s    = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
    r_s    = a[31] ? (~r_mag + 32'd1) : r_mag;
    b_udiv = (b == 32'd0) ? 32'd1 : b;
    q_u    = a / b_udiv;
    r_u    = a % b_udiv;
    case (op)
      OP_MULT:  result = mul_s;
      OP_MULTU: result = mul_u;
      OP_DIV:   result = {r_s, q_s};
      default:  result = {r_u, q_u};
    endcase
  end

  assign commit_ok = !(((op_q == OP_DIV) || (op_q == OP_DIVU)) && zero_q);

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    op_next      = op_q;
    pending_next = pending;
    zero_next    = zero_q;
    hi_next      = hi;
    lo_next      = lo;
    done_next    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              op_next      = op;
              pending_next = result;
              zero_next    = (b == 32'd0);
              cnt_next     = op[1] ? DIV_LOAD : MULT_LOAD;
              state_next   = RUN;
            end
            OP_MTHI: hi_next = a;
            OP_MTLO: lo_next = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_next = cnt - 5'd1;
        if (cnt == 5'd1) begin
          state_next = IDLE;
          done_next  = 1'b1;
          if (commit_ok) begin
            hi_next = pending[63:32];
            lo_next = pending[31:0];
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      op_q    <= 3'd0;
      pending <= 64'd0;
      zero_q  <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      op_q    <= op_next;
      pending <= pending_next;
      zero_q  <= zero_next;
      hi      <= hi_next;
      lo      <= lo_next;
      done    <= done_next;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, results, div-by-zero, ignored starts and async reset.
`timescale 1ns/1ps
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b110;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'b110;
  endtask

  task automatic wait_idle(output int cycles, output bit moved);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    cycles = 0; moved = 1'b0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
      if (busy === 1'b1 && (hi !== h0 || lo !== l0)) moved = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b1; op = 3'b000; a = 32'd7; b = 32'd9;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: got busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
    end
    start = 1'b0; op = 3'b110;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: got busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
    end
  endtask

  task automatic test_mult;
    int cyc; bit moved;
    issue(3'b000, 32'hFFFFFFFE, 32'd3);
    wait_idle(cyc, moved);
    vectors++;
    if (cyc != 5 || moved) begin
      miscompares++;
      $display("[TB] FAIL mult_busy: got %0d cycles (hold_broken=%b), want 5 (0)", cyc, moved);
    end
    vectors++;
    if (done !== 1'b1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      miscompares++;
      $display("[TB] FAIL mult_result: got done=%b hi=%h lo=%h, want 1 ffffffff fffffffa", done, hi, lo);
    end
    issue(3'b001, 32'hFFFFFFFE, 32'd3);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL multu_b2b: got done=%b busy=%b, want 0 1", done, busy);
    end
    wait_idle(cyc, moved);
    vectors++;
    if (cyc != 5 || done !== 1'b1 || hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin
      miscompares++;
      $display("[TB] FAIL multu_result: got cyc=%0d done=%b hi=%h lo=%h, want 5 1 00000002 fffffffa", cyc, done, hi, lo);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL done_pulse: got done=%b one cycle later, want 0", done);
    end
  endtask

  task automatic test_div;
    int cyc; bit moved;
    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    wait_idle(cyc, moved);
    vectors++;
    if (cyc != 10 || moved || done !== 1'b1 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      miscompares++;
      $display("[TB] FAIL div_neg: got cyc=%0d done=%b hi=%h lo=%h, want 10 1 ffffffff fffffffd", cyc, done, hi, lo);
    end
    issue(3'b011, 32'd7, 32'd2);
    wait_idle(cyc, moved);
    vectors++;
    if (cyc != 10 || hi !== 32'd1 || lo !== 32'd3) begin
      miscompares++;
      $display("[TB] FAIL divu: got cyc=%0d hi=%h lo=%h, want 10 00000001 00000003", cyc, hi, lo);
    end
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(cyc, moved);
    vectors++;
    if (cyc != 10 || hi !== 32'd0 || lo !== 32'h80000000) begin
      miscompares++;
      $display("[TB] FAIL div_overflow: got cyc=%0d hi=%h lo=%h, want 10 00000000 80000000", cyc, hi, lo);
    end
  endtask

  task automatic test_div_zero;
    int cyc; bit moved;
    issue(3'b100, 32'h12345678, 32'd0);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h12345678) begin
      miscompares++;
      $display("[TB] FAIL mthi: got busy=%b done=%b hi=%h, want 0 0 12345678", busy, done, hi);
    end
    issue(3'b101, 32'h9ABCDEF0, 32'd0);
    vectors++;
    if (busy !== 1'b0 || lo !== 32'h9ABCDEF0 || hi !== 32'h12345678) begin
      miscompares++;
      $display("[TB] FAIL mtlo: got busy=%b hi=%h lo=%h, want 0 12345678 9abcdef0", busy, hi, lo);
    end
    issue(3'b010, 32'd55, 32'd0);
    wait_idle(cyc, moved);
    vectors++;
    if (cyc != 10 || done !== 1'b1 || hi !== 32'h12345678 || lo !== 32'h9ABCDEF0) begin
      miscompares++;
      $display("[TB] FAIL div_zero: got cyc=%0d done=%b hi=%h lo=%h, want 10 1 12345678 9abcdef0", cyc, done, hi, lo);
    end
  endtask

  task automatic test_start_during_busy;
    int cyc; bit moved;
    issue(3'b000, 32'd5, 32'd6);
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'hDEADBEEF;
    @(negedge clk);
    op = 3'b011; a = 32'd9; b = 32'd2;
    @(negedge clk);
    start = 1'b0; op = 3'b110; a = 32'd1000; b = 32'd1000;
    wait_idle(cyc, moved);
    vectors++;
    if (cyc + 3 != 5 || hi !== 32'd0 || lo !== 32'd30) begin
      miscompares++;
      $display("[TB] FAIL busy_ignore: got cyc=%0d hi=%h lo=%h, want 5 00000000 0000001e", cyc + 3, hi, lo);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || hi !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL busy_ignore_after: got busy=%b hi=%h, want 0 00000000", busy, hi);
    end
  endtask

  task automatic test_reset_mid;
    int cyc; bit moved; bit saw_done;
    issue(3'b011, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got busy=%b hi=%h lo=%h, want 0 0 0", busy, hi, lo);
    end
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done || hi !== 32'd0 || lo !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_no_done: got saw_done=%b hi=%h lo=%h, want 0 0 0", saw_done, hi, lo);
    end
    issue(3'b001, 32'd3, 32'd4);
    wait_idle(cyc, moved);
    vectors++;
    if (cyc != 5 || done !== 1'b1 || hi !== 32'd0 || lo !== 32'd12) begin
      miscompares++;
      $display("[TB] FAIL post_reset_multu: got cyc=%0d done=%b hi=%h lo=%h, want 5 1 0 0000000c", cyc, done, hi, lo);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_start_during_busy;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
